// File: rtl/cpu_defs.sv
// cpu_defs: definitions shared between the ALU operand sequencer, the ALU and
// the ALU result latch.
//   - datapath and opcode widths
//   - sequencer state encoding (IDLE=0, LD_A, LD_B, EXEC, DONE)
//   - ALU opcode constants understood by the ALU behind the result latch
package cpu_defs;

  localparam int WIDTH = 8;
  localparam int OPW   = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LD_A = 3'd1,
    S_LD_B = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // ALU opcodes. OP_ADD honours the sub select (a + ~b + 1 when sub = 1).
  localparam logic [OPW-1:0] OP_ADD = 4'h0;
  localparam logic [OPW-1:0] OP_AND = 4'h1;
  localparam logic [OPW-1:0] OP_OR  = 4'h2;
  localparam logic [OPW-1:0] OP_XOR = 4'h3;

endpackage

// File: rtl/load_reg.sv
// load_reg: WIDTH-bit register with load enable and asynchronous active-low
// clear. Holds its value whenever load_i is low.
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous clear, active-low
//   load_i  capture d_i at the next rising edge
//   d_i     data to capture
//   q_o     registered value
module load_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: control/operand stage directly upstream of the ALU result
// latch. Accepts a command (opcode + sub), fetches operand A then operand B
// from the shared bus, drives them to the ALU latch for one EXEC cycle with
// out_en high, captures the driven result/carry and publishes result plus
// C/Z/N flags with a one-cycle done pulse.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, op_in, sub_in    command request and its opcode / subtract select
//   abort                   cancel the command in LD_A, LD_B or EXEC
//   bus_in, bus_valid       operand source; bus_ready is driven by this block
//   alu_a, alu_b, alu_op,
//   alu_sub, alu_out_en     registered drive into the ALU latch
//   alu_result, alu_cout    ALU latch output, meaningful while alu_out_en = 1
//   busy, done              status (busy outside IDLE, done pulse in DONE)
//   result, flag_c/z/n      last captured result and its flags
//   dbg_state_o             current FSM state, for observation only
//
// Bus handshake: bus_ready is high exactly in LD_A and LD_B. An operand word
// moves on a rising edge where bus_valid & bus_ready are both high; the source
// may hold bus_valid low for any number of cycles and the FSM simply waits.
module alu_op_sequencer
  import cpu_defs::*;
#(
  parameter int WIDTH = cpu_defs::WIDTH,
  parameter int OPW   = cpu_defs::OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPW-1:0]   op_in,
  input  logic             sub_in,
  input  logic             abort,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             bus_valid,
  output logic             bus_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_sub,
  output logic             alu_out_en,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output state_t           dbg_state_o
);

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q;
  logic           sub_q;
  logic           flag_c_q, flag_z_q, flag_n_q;
  logic           ready_q, out_en_q, busy_q, done_q;

  logic xfer;
  logic accept;
  logic load_a, load_b, capture;

  assign xfer    = bus_valid & ready_q;
  // A new command is only taken when the previous one has finished.
  assign accept  = start & ((state_q == S_IDLE) | (state_q == S_DONE));
  // abort wins over an operand transfer and over the EXEC capture.
  assign load_a  = (state_q == S_LD_A) & xfer & ~abort;
  assign load_b  = (state_q == S_LD_B) & xfer & ~abort;
  assign capture = (state_q == S_EXEC) & ~abort;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LD_A;
      S_LD_A: begin
        if (abort)          state_d = S_IDLE;
        else if (bus_valid) state_d = S_LD_B;
      end
      S_LD_B: begin
        if (abort)          state_d = S_IDLE;
        else if (bus_valid) state_d = S_EXEC;
      end
      S_EXEC: state_d = abort ? S_IDLE : S_DONE;
      S_DONE: state_d = start ? S_LD_A : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state register and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sub_q    <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      ready_q  <= 1'b0;
      out_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= (state_d == S_LD_A) | (state_d == S_LD_B);
      out_en_q <= (state_d == S_EXEC);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      if (accept) begin
        op_q  <= op_in;
        sub_q <= sub_in;
      end
      if (capture) begin
        flag_c_q <= alu_cout;
        flag_z_q <= (alu_result == '0);
        flag_n_q <= alu_result[WIDTH-1];
      end
    end
  end

  load_reg #(.WIDTH(WIDTH)) u_reg_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (load_a),
    .d_i    (bus_in),
    .q_o    (alu_a)
  );

  load_reg #(.WIDTH(WIDTH)) u_reg_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (load_b),
    .d_i    (bus_in),
    .q_o    (alu_b)
  );

  load_reg #(.WIDTH(WIDTH)) u_reg_result (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (capture),
    .d_i    (alu_result),
    .q_o    (result)
  );

  assign bus_ready   = ready_q;
  assign alu_out_en  = out_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign alu_op      = op_q;
  assign alu_sub     = sub_q;
  assign flag_c      = flag_c_q;
  assign flag_z      = flag_z_q;
  assign flag_n      = flag_n_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  import cpu_defs::*;

  localparam int W  = 8;
  localparam int OW = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [OW-1:0] op_in = '0;
  logic          sub_in = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  bus_in = '0;
  logic          bus_valid = 1'b0;
  logic          bus_ready;
  logic [W-1:0]  alu_a, alu_b;
  logic [OW-1:0] alu_op;
  logic          alu_sub, alu_out_en;
  logic [W-1:0]  alu_result;
  logic          alu_cout;
  logic          busy, done;
  logic [W-1:0]  result;
  logic          flag_c, flag_z, flag_n;
  state_t        dbg_state;

  alu_op_sequencer #(.WIDTH(W), .OPW(OW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_in(op_in), .sub_in(sub_in),
    .abort(abort), .bus_in(bus_in), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sub(alu_sub),
    .alu_out_en(alu_out_en), .alu_result(alu_result), .alu_cout(alu_cout),
    .busy(busy), .done(done), .result(result), .flag_c(flag_c), .flag_z(flag_z),
    .flag_n(flag_n), .dbg_state_o(dbg_state)
  );

  // ---------------- ALU environment model ----------------
  function automatic logic [W:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [OW-1:0] op, input logic s);
    case (op)
      OP_ADD:  alu_fn = s ? ({1'b0, a} + {1'b0, ~b} + 9'd1) : ({1'b0, a} + {1'b0, b});
      OP_AND:  alu_fn = {1'b0, a & b};
      OP_OR:   alu_fn = {1'b0, a | b};
      OP_XOR:  alu_fn = {1'b0, a ^ b};
      default: alu_fn = {1'b0, a};
    endcase
  endfunction

  // Outside EXEC the latch output is junk so a mistimed capture shows up.
  logic [W-1:0] junk_r = '0;
  logic         junk_c = 1'b0;
  logic [W:0]   alu_full;
  always @(negedge clk) begin
    junk_r = W'($urandom);
    junk_c = 1'($urandom);
  end
  assign alu_full   = alu_fn(alu_a, alu_b, alu_op, alu_sub);
  assign alu_result = alu_out_en ? alu_full[W-1:0] : junk_r;
  assign alu_cout   = alu_out_en ? alu_full[W] : junk_c;

  // ---------------- scoreboard / reference state ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_c_q[$];
  logic [W-1:0]  m_a, m_b, m_res;
  logic [OW-1:0] m_op;
  logic          m_sub, m_c;

  task automatic model_reset();
    m_a = '0; m_b = '0; m_res = '0; m_op = '0; m_sub = 1'b0; m_c = 1'b0;
    exp_q.delete();
    exp_c_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Issues one command from IDLE or DONE (called at a negedge) and follows it
  // to its done pulse, checking operands, latency and the published result.
  task automatic run_cmd(input logic [OW-1:0] op, input logic sub, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int sa, input int sb);
    logic [W:0]   full;
    logic [W-1:0] er;
    logic         ec;
    int edges, en_cnt;
    bit got;
    full = alu_fn(a, b, op, sub);
    exp_q.push_back(full[W-1:0]);
    exp_c_q.push_back(full[W]);
    start = 1'b1; op_in = op; sub_in = sub; bus_valid = 1'b0; bus_in = W'($urandom);
    @(negedge clk); edges = 1;
    m_op = op; m_sub = sub;
    n_chk++;
    if (dbg_state !== S_LD_A || bus_ready !== 1'b1 || alu_op !== op || alu_sub !== sub) begin
      n_err++;
      $display("FAIL accept: state=%0d ready=%b op=%h sub=%b, want state=%0d ready=1 op=%h sub=%b",
               dbg_state, bus_ready, alu_op, alu_sub, S_LD_A, op, sub);
    end
    // Stalls: start with a different opcode is pushed while busy and must be ignored.
    for (int i = 0; i < sa; i++) begin
      start = 1'($urandom); op_in = OW'($urandom); sub_in = 1'($urandom);
      bus_valid = 1'b0; bus_in = W'($urandom);
      @(negedge clk); edges++;
    end
    start = 1'($urandom); op_in = OW'($urandom); bus_valid = 1'b1; bus_in = a;
    @(negedge clk); edges++;
    for (int i = 0; i < sb; i++) begin
      start = 1'($urandom); op_in = OW'($urandom); sub_in = 1'($urandom);
      bus_valid = 1'b0; bus_in = W'($urandom);
      @(negedge clk); edges++;
    end
    start = 1'b0; bus_valid = 1'b1; bus_in = b;
    @(negedge clk); edges++;
    bus_valid = 1'b0; bus_in = W'($urandom);
    en_cnt = 0; got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      if (alu_out_en === 1'b1) en_cnt++;
      if (done === 1'b1) got = 1;
      else begin @(negedge clk); edges++; end
    end
    er = exp_q.pop_front();
    ec = exp_c_q.pop_front();
    n_chk++;
    if (!got) begin
      n_err++;
      $display("FAIL done_timeout: done not seen within budget, want at edge %0d", 4 + sa + sb);
      return;
    end
    m_a = a; m_b = b; m_res = er; m_c = ec;
    n_chk++;
    if (edges != 4 + sa + sb) begin
      n_err++;
      $display("FAIL latency: done after %0d edges, want %0d", edges, 4 + sa + sb);
    end
    n_chk++;
    if (en_cnt != 1) begin
      n_err++;
      $display("FAIL out_en_cycles: got %0d, want 1", en_cnt);
    end
    n_chk++;
    if (result !== er || flag_c !== ec || flag_z !== (er == '0) || flag_n !== er[W-1]) begin
      n_err++;
      $display("FAIL result: got %h c=%b z=%b n=%b, want %h c=%b z=%b n=%b",
               result, flag_c, flag_z, flag_n, er, ec, (er == '0), er[W-1]);
    end
    n_chk++;
    if (alu_a !== a || alu_b !== b || alu_op !== op || alu_sub !== sub || busy !== 1'b1) begin
      n_err++;
      $display("FAIL operands: a=%h b=%h op=%h sub=%b busy=%b, want a=%h b=%h op=%h sub=%b busy=1",
               alu_a, alu_b, alu_op, alu_sub, busy, a, b, op, sub);
    end
  endtask

  // One cycle with start low after DONE: expect IDLE with all strobes low.
  task automatic idle_gap();
    start = 1'b0; bus_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (dbg_state !== S_IDLE || busy !== 1'b0 || done !== 1'b0 || bus_ready !== 1'b0
        || alu_out_en !== 1'b0) begin
      n_err++;
      $display("FAIL idle: state=%0d busy=%b done=%b ready=%b en=%b, want IDLE with all low",
               dbg_state, busy, done, bus_ready, alu_out_en);
    end
  endtask

  task automatic check_held(input string tag);
    n_chk++;
    if (alu_a !== m_a || alu_b !== m_b || alu_op !== m_op || alu_sub !== m_sub || result !== m_res
        || flag_c !== m_c || flag_z !== (m_res == '0) || flag_n !== m_res[W-1]) begin
      n_err++;
      $display("FAIL %s: a=%h b=%h op=%h sub=%b res=%h c=%b z=%b n=%b, want a=%h b=%h op=%h sub=%b res=%h c=%b",
               tag, alu_a, alu_b, alu_op, alu_sub, result, flag_c, flag_z, flag_n,
               m_a, m_b, m_op, m_sub, m_res, m_c);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({alu_a, alu_b, alu_op, alu_sub, alu_out_en, bus_ready, busy, done, result,
         flag_c, flag_z, flag_n} !== '0 || dbg_state !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_power_on: outputs or state nonzero (state=%0d)", dbg_state);
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_add();
    run_cmd(OP_ADD, 1'b0, 8'h25, 8'h17, 0, 0);
    idle_gap();
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op_in = OP_OR; sub_in = 1'b1;
    @(negedge clk);
    start = 1'b0; bus_valid = 1'b1; bus_in = 8'hA5;
    @(negedge clk);
    bus_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({alu_a, alu_b, alu_op, alu_sub, alu_out_en, bus_ready, busy, done, result,
         flag_c, flag_z, flag_n} !== '0 || dbg_state !== S_IDLE) begin
      n_err++;
      $display("FAIL reset_mid: state=%0d a=%h res=%h busy=%b ready=%b, want all 0 in IDLE",
               dbg_state, alu_a, result, busy, bus_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    run_cmd(OP_XOR, 1'b0, 8'h5A, 8'h0F, 0, 0);
    idle_gap();
  endtask

  task automatic test_sub_zero();
    run_cmd(OP_ADD, 1'b1, 8'h40, 8'h40, 0, 0);
    idle_gap();
    run_cmd(OP_ADD, 1'b0, 8'hFF, 8'h01, 0, 0);
    idle_gap();
  endtask

  task automatic test_stalls();
    run_cmd(OP_ADD, 1'b0, 8'h81, 8'h02, 3, 2);
    idle_gap();
  endtask

  // stage: 0 = abort in LD_A, 1 = in LD_B (with valid high), 2 = in EXEC
  task automatic abort_at(input int stage);
    bit seen_done;
    start = 1'b1; op_in = OP_AND; sub_in = 1'($urandom);
    @(negedge clk);
    m_op = OP_AND; m_sub = sub_in;
    start = 1'b0;
    if (stage >= 1) begin
      bus_valid = 1'b1; bus_in = W'($urandom);
      @(negedge clk);
      m_a = bus_in;
    end
    if (stage == 2) begin
      bus_valid = 1'b1; bus_in = W'($urandom);
      @(negedge clk);
      m_b = bus_in;
    end
    bus_valid = 1'b1; bus_in = W'($urandom); abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; bus_valid = 1'b0;
    n_chk++;
    if (dbg_state !== S_IDLE || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state stage%0d: state=%0d busy=%b done=%b, want IDLE 0 0",
               stage, dbg_state, busy, done);
    end
    check_held("abort_hold");
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1;
    end
    n_chk++;
    if (seen_done) begin
      n_err++;
      $display("FAIL abort_no_done stage%0d: done=1 seen, want 0", stage);
    end
  endtask

  task automatic test_abort();
    abort_at(0);
    abort_at(1);
    abort_at(2);
  endtask

  task automatic test_back_to_back();
    run_cmd(OP_ADD, 1'b0, 8'h10, 8'h20, 0, 0);
    run_cmd(OP_OR, 1'b0, 8'h0C, 8'h30, 1, 0);
    run_cmd(OP_ADD, 1'b1, 8'h01, 8'h02, 0, 1);
    idle_gap();
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      run_cmd(OW'($urandom_range(0, 4)), 1'($urandom), W'($urandom), W'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) idle_gap();
    end
    idle_gap();
    check_held("random_final_hold");
  endtask

  initial begin
    test_reset();
    test_add();
    test_reset_mid();
    test_sub_zero();
    test_stalls();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
